// File: rtl/parking_keypad_tx_if.sv
// Keypad-to-controller bundle: keypad/sensor inputs and the three command channels.
interface parking_keypad_tx_if #(
  parameter int unsigned PW_BYTES = 16
);
  localparam int unsigned PwW = 8 * PW_BYTES;

  logic           key_valid;
  logic [7:0]     key_code;
  logic           ir;
  logic           exit_req;
  logic           full;
  logic [PwW-1:0] pass_entry1;
  logic           enter1;
  logic [PwW-1:0] pass_entry2;
  logic           enter2;
  logic [3:0]     exit_num;
  logic [PwW-1:0] pass_exit;
  logic           enter3;
  logic           busy;
  logic           rejected;
  logic           key_err;
  logic           timeout;

  // The front end drives the controller's command side.
  modport master (
    input  key_valid, key_code, ir, exit_req, full,
    output pass_entry1, enter1, pass_entry2, enter2, exit_num, pass_exit, enter3,
           busy, rejected, key_err, timeout
  );

  // Keypad scanner / sensors on one side, parking controller on the other.
  modport slave (
    output key_valid, key_code, ir, exit_req, full,
    input  pass_entry1, enter1, pass_entry2, enter2, exit_num, pass_exit, enter3,
           busy, rejected, key_err, timeout
  );
endinterface

// File: rtl/parking_keypad_tx.sv
// Driver-side keypad front end: assembles ASCII keys into passwords and issues
// entry / confirm / exit commands to the parking controller.
module parking_keypad_tx #(
  parameter int unsigned PW_BYTES    = 16,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input logic                 clk,
  input logic                 rst_n,
  parking_keypad_tx_if.master bus
);
  localparam int unsigned PwW  = 8 * PW_BYTES;
  localparam int unsigned CntW = $clog2(PW_BYTES + 1);
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYC);

  typedef enum logic [2:0] {StIdle, StEnt1, StEnt2, StExSlot, StExPass} state_e;

  state_e          state_q;
  logic            ir_q;
  logic [PwW-1:0]  pw_q;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      slot_q;
  logic            slot_vld_q;
  logic [TmrW-1:0] tmr_q;
  logic [PwW-1:0]  pass1_q, pass2_q, pass3_q;
  logic [3:0]      exit_num_q;
  logic            enter1_q, enter2_q, enter3_q;
  logic            rejected_q, key_err_q, timeout_q;

  logic       ir_rise, is_print, is_enter, is_bksp, is_esc, cnt_full;
  logic       hex_ok;
  logic [3:0] hex_val;

  assign ir_rise  = bus.ir & ~ir_q;
  assign is_print = (bus.key_code >= 8'h20) && (bus.key_code <= 8'h7e);
  assign is_enter = (bus.key_code == 8'h0d);
  assign is_bksp  = (bus.key_code == 8'h08);
  assign is_esc   = (bus.key_code == 8'h1b);
  assign cnt_full = (cnt_q == CntW'(PW_BYTES));

  // Hex slot digit decode; letters map via the low nibble plus 9.
  always_comb begin
    hex_ok  = 1'b0;
    hex_val = 4'h0;
    if (bus.key_code >= 8'h30 && bus.key_code <= 8'h39) begin
      hex_ok  = 1'b1;
      hex_val = bus.key_code[3:0];
    end else if ((bus.key_code >= 8'h41 && bus.key_code <= 8'h46) ||
                 (bus.key_code >= 8'h61 && bus.key_code <= 8'h66)) begin
      hex_ok  = 1'b1;
      hex_val = bus.key_code[3:0] + 4'd9;
    end
  end

  // Sequencer: state, password buffer, idle timer and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ir_q       <= 1'b0;
      pw_q       <= '0;
      cnt_q      <= '0;
      slot_q     <= '0;
      slot_vld_q <= 1'b0;
      tmr_q      <= '0;
      pass1_q    <= '0;
      pass2_q    <= '0;
      pass3_q    <= '0;
      exit_num_q <= '0;
      enter1_q   <= 1'b0;
      enter2_q   <= 1'b0;
      enter3_q   <= 1'b0;
      rejected_q <= 1'b0;
      key_err_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      ir_q       <= bus.ir;
      enter1_q   <= 1'b0;
      enter2_q   <= 1'b0;
      enter3_q   <= 1'b0;
      rejected_q <= 1'b0;
      key_err_q  <= 1'b0;
      timeout_q  <= 1'b0;

      // Timer is held at zero in IDLE, so every sequence starts from a fresh count.
      if (state_q == StIdle || bus.key_valid) tmr_q <= '0;
      else                                    tmr_q <= tmr_q + 1'b1;

      if (state_q == StIdle) begin
        // Entry has priority over a simultaneous exit request.
        if (ir_rise) begin
          if (bus.full) begin
            rejected_q <= 1'b1;
          end else begin
            state_q <= StEnt1;
            pw_q    <= '0;
            cnt_q   <= '0;
          end
        end else if (bus.exit_req) begin
          state_q    <= StExSlot;
          slot_q     <= '0;
          slot_vld_q <= 1'b0;
        end
      end else if (bus.key_valid) begin
        // A key arriving on the expiry cycle counts as activity, so no timeout.
        if (is_esc) begin
          state_q    <= StIdle;
          pw_q       <= '0;
          cnt_q      <= '0;
          slot_q     <= '0;
          slot_vld_q <= 1'b0;
        end else if (state_q == StExSlot) begin
          if (hex_ok) begin
            slot_q     <= hex_val;
            slot_vld_q <= 1'b1;
          end else if (is_print) begin
            key_err_q <= 1'b1;
          end else if (is_enter) begin
            if (slot_vld_q) state_q   <= StExPass;
            else            key_err_q <= 1'b1;
          end
        end else if (is_print) begin
          if (cnt_full) begin
            key_err_q <= 1'b1;
          end else begin
            pw_q  <= {pw_q[PwW-9:0], bus.key_code};
            cnt_q <= cnt_q + 1'b1;
          end
        end else if (is_bksp) begin
          pw_q <= pw_q >> 8;
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end else if (is_enter) begin
          if (cnt_q == '0) begin
            key_err_q <= 1'b1;
          end else begin
            pw_q  <= '0;
            cnt_q <= '0;
            unique case (state_q)
              StEnt1: begin
                pass1_q  <= pw_q;
                enter1_q <= 1'b1;
                state_q  <= StEnt2;
              end
              StEnt2: begin
                pass2_q  <= pw_q;
                enter2_q <= 1'b1;
                state_q  <= StIdle;
              end
              StExPass: begin
                pass3_q    <= pw_q;
                exit_num_q <= slot_q;
                enter3_q   <= 1'b1;
                state_q    <= StIdle;
                slot_vld_q <= 1'b0;
              end
              default: ;
            endcase
          end
        end
      end else if (tmr_q == TmrW'(TIMEOUT_CYC - 1)) begin
        // Abort the open sequence; previously issued command data stays visible.
        timeout_q  <= 1'b1;
        state_q    <= StIdle;
        pw_q       <= '0;
        cnt_q      <= '0;
        slot_q     <= '0;
        slot_vld_q <= 1'b0;
      end
    end
  end

  assign bus.pass_entry1 = pass1_q;
  assign bus.enter1      = enter1_q;
  assign bus.pass_entry2 = pass2_q;
  assign bus.enter2      = enter2_q;
  assign bus.exit_num    = exit_num_q;
  assign bus.pass_exit   = pass3_q;
  assign bus.enter3      = enter3_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.rejected    = rejected_q;
  assign bus.key_err     = key_err_q;
  assign bus.timeout     = timeout_q;
endmodule

// File: tb/tb_parking_keypad_tx.sv
// Bench for parking_keypad_tx: directed scenarios plus randomized passwords and
// slot digits, checked against a queue-based password model.
module tb_parking_keypad_tx;
  localparam int unsigned PwBytes    = 16;
  localparam int unsigned TimeoutCyc = 16;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  parking_keypad_tx_if #(.PW_BYTES(PwBytes)) bus ();

  parking_keypad_tx #(
    .PW_BYTES   (PwBytes),
    .TIMEOUT_CYC(TimeoutCyc)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int c_e1 = 0, c_e2 = 0, c_e3 = 0, c_rej = 0, c_kerr = 0, c_to = 0;
  logic [127:0] last_p1 = '0, last_p3 = '0;
  logic [3:0]   last_slot = '0;

  // Strobe tallies, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (bus.enter1 === 1'b1)   c_e1++;
    if (bus.enter2 === 1'b1)   c_e2++;
    if (bus.enter3 === 1'b1)   c_e3++;
    if (bus.rejected === 1'b1) c_rej++;
    if (bus.key_err === 1'b1)  c_kerr++;
    if (bus.timeout === 1'b1)  c_to++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Characters typed, left to right, become a right-justified big-endian number.
  function automatic logic [127:0] pack(input bq_t q);
    logic [127:0] r;
    r = '0;
    foreach (q[i]) r = (r << 8) | 128'(q[i]);
    return r;
  endfunction

  // Reference: edit a list of characters as a user would see it on screen.
  task automatic type_model(input bq_t keys, output logic [127:0] pw, output int errs);
    bq_t q;
    errs = 0;
    foreach (keys[i]) begin
      if (keys[i] == 8'h08) begin
        if (q.size() > 0) void'(q.pop_back());
      end else if (q.size() == PwBytes) begin
        errs++;
      end else begin
        q.push_back(keys[i]);
      end
    end
    pw = pack(q);
  endtask

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic bq_t rand_keys();
    bq_t q;
    int n;
    n = $urandom_range(1, 20);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 5) == 0) q.push_back(8'h08);
      else                           q.push_back(8'($urandom_range(32, 126)));
    end
    q.push_back(8'($urandom_range(32, 126)));
    return q;
  endfunction

  function automatic logic [7:0] hexchar(input int v);
    if (v < 10)                    return 8'(48 + v);
    if ($urandom_range(0, 1) == 1) return 8'(55 + v);
    return 8'(87 + v);
  endfunction

  task automatic press(input logic [7:0] k);
    bus.key_valid = 1'b1;
    bus.key_code  = k;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.key_code  = 8'h00;
  endtask

  task automatic ir_rise();
    bus.ir = 1'b0;
    @(negedge clk);
    bus.ir = 1'b1;
    @(negedge clk);
    bus.ir = 1'b0;
  endtask

  task automatic exit_pulse();
    bus.exit_req = 1'b1;
    @(negedge clk);
    bus.exit_req = 1'b0;
  endtask

  // Type keys, press ENTER, and check the strobe/payload of the chosen channel.
  task automatic submit(input bq_t keys, input int port, input logic [3:0] slot,
                        input string tag);
    logic [127:0] exp_pw;
    int exp_err, e0;
    type_model(keys, exp_pw, exp_err);
    e0 = c_kerr;
    foreach (keys[i]) press(keys[i]);
    check({tag, " key_err count"}, 128'(c_kerr - e0), 128'(exp_err));
    press(8'h0d);
    if (port == 1) begin
      check({tag, " enter1"}, 128'(bus.enter1), 128'(1));
      check({tag, " pass_entry1"}, bus.pass_entry1, exp_pw);
      last_p1 = exp_pw;
    end else if (port == 2) begin
      check({tag, " enter2"}, 128'(bus.enter2), 128'(1));
      check({tag, " pass_entry2"}, bus.pass_entry2, exp_pw);
    end else begin
      check({tag, " enter3"}, 128'(bus.enter3), 128'(1));
      check({tag, " pass_exit"}, bus.pass_exit, exp_pw);
      check({tag, " exit_num"}, 128'(bus.exit_num), 128'(slot));
      last_p3   = exp_pw;
      last_slot = slot;
    end
    @(negedge clk);
    check({tag, " strobe one cycle"}, 128'({bus.enter1, bus.enter2, bus.enter3}), 128'(0));
  endtask

  initial begin
    bq_t k;
    int  e0, e1, e3, v, v2;

    bus.key_valid = 1'b0;
    bus.key_code  = 8'h00;
    bus.ir        = 1'b0;
    bus.exit_req  = 1'b0;
    bus.full      = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("reset busy", 128'(bus.busy), 128'(0));
    check("reset strobes", 128'({bus.enter1, bus.enter2, bus.enter3, bus.rejected,
                                 bus.key_err, bus.timeout}), 128'(0));
    check("reset pass_entry1", bus.pass_entry1, 128'(0));
    check("reset pass_exit", bus.pass_exit, 128'(0));
    check("reset exit_num", 128'(bus.exit_num), 128'(0));

    // Keys in IDLE are ignored
    e0 = c_kerr;
    press("A");
    press(8'h0d);
    check("idle keys busy", 128'(bus.busy), 128'(0));
    check("idle keys key_err", 128'(c_kerr - e0), 128'(0));
    check("idle keys enter1", 128'(c_e1), 128'(0));

    // T1: entry and confirm
    k = str2q("sentence2encrypt");
    ir_rise();
    check("T1 busy", 128'(bus.busy), 128'(1));
    submit(k, 1, 4'h0, "T1 entry");
    check("T1 literal1", bus.pass_entry1, 128'h73656E74656E6365_32656E6372797074);
    submit(k, 2, 4'h0, "T1 confirm");
    check("T1 literal2", bus.pass_entry2, 128'h73656E74656E6365_32656E6372797074);
    check("T1 idle", 128'(bus.busy), 128'(0));

    // T2: exit
    exit_pulse();
    press("3");
    press(8'h0d);
    submit(str2q("a9d"), 3, 4'h3, "T2 exit");
    check("T2 literal", bus.pass_exit, 128'h613964);

    // T3: lot full
    e1 = c_e1;
    e0 = c_rej;
    bus.full = 1'b1;
    ir_rise();
    repeat (3) @(negedge clk);
    check("T3 rejected once", 128'(c_rej - e0), 128'(1));
    check("T3 busy", 128'(bus.busy), 128'(0));
    check("T3 no enter1", 128'(c_e1 - e1), 128'(0));
    bus.full = 1'b0;

    // T4: empty ENTER, overflow, backspace
    ir_rise();
    e1 = c_e1;
    e0 = c_kerr;
    press(8'h0d);
    check("T4 empty enter key_err", 128'(c_kerr - e0), 128'(1));
    check("T4 empty enter no strobe", 128'(c_e1 - e1), 128'(0));
    k = {};
    for (int i = 0; i < 17; i++) k.push_back(8'($urandom_range(32, 126)));
    e0 = c_kerr;
    for (int i = 0; i < 16; i++) press(k[i]);
    check("T4 16 chars no err", 128'(c_kerr - e0), 128'(0));
    press(k[16]);
    check("T4 char17 key_err", 128'(bus.key_err), 128'(1));
    press(8'h0d);
    check("T4 enter1", 128'(bus.enter1), 128'(1));
    k.delete(16);
    check("T4 first 16 chars", bus.pass_entry1, pack(k));
    last_p1 = pack(k);
    submit('{8'h78, 8'h08, 8'h79}, 2, 4'h0, "T4 bksp");
    check("T4 bksp literal", bus.pass_entry2, 128'h79);

    // Randomized entry/confirm pairs
    for (int r = 0; r < 6; r++) begin
      ir_rise();
      submit(rand_keys(), 1, 4'h0, $sformatf("rand entry%0d", r));
      submit(rand_keys(), 2, 4'h0, $sformatf("rand confirm%0d", r));
    end

    // Randomized exits: bad char, ENTER without slot, slot overwrite
    for (int r = 0; r < 6; r++) begin
      exit_pulse();
      e0 = c_kerr;
      v  = $urandom_range(0, 15);
      v2 = $urandom_range(0, 15);
      press(8'($urandom_range(103, 122)));
      press(8'h0d);
      press(hexchar(v));
      press(hexchar(v2));
      press(8'h0d);
      check($sformatf("rand exit%0d slot key_err", r), 128'(c_kerr - e0), 128'(2));
      submit(rand_keys(), 3, 4'(v2), $sformatf("rand exit%0d", r));
    end

    // T5: timeout after TimeoutCyc idle cycles
    e1 = c_e1;
    e0 = c_to;
    ir_rise();
    repeat (TimeoutCyc - 1) @(negedge clk);
    check("T5 no early timeout", 128'(c_to - e0), 128'(0));
    check("T5 still busy", 128'(bus.busy), 128'(1));
    @(negedge clk);
    check("T5 timeout pulse", 128'(bus.timeout), 128'(1));
    check("T5 idle", 128'(bus.busy), 128'(0));
    check("T5 no enter1", 128'(c_e1 - e1), 128'(0));
    check("T5 pass_entry1 held", bus.pass_entry1, last_p1);
    @(negedge clk);
    check("T5 timeout one cycle", 128'(c_to - e0), 128'(1));

    // T5: ESC in EX_PASS
    e3 = c_e3;
    exit_pulse();
    press("f");
    press(8'h0d);
    press("a");
    press(8'h1b);
    check("T5 esc idle", 128'(bus.busy), 128'(0));
    press(8'h0d);
    @(negedge clk);
    check("T5 esc no enter3", 128'(c_e3 - e3), 128'(0));
    check("T5 pass_exit held", bus.pass_exit, last_p3);
    check("T5 exit_num held", 128'(bus.exit_num), 128'(last_slot));

    // T6: simultaneous ir rise and exit_req, then reset on the ENTER cycle
    bus.ir = 1'b0;
    @(negedge clk);
    bus.ir       = 1'b1;
    bus.exit_req = 1'b1;
    @(negedge clk);
    bus.ir       = 1'b0;
    bus.exit_req = 1'b0;
    check("T6 busy", 128'(bus.busy), 128'(1));
    e0 = c_kerr;
    press("Z");
    check("T6 entry wins (no key_err)", 128'(c_kerr - e0), 128'(0));
    e1 = c_e1;
    bus.key_valid = 1'b1;
    bus.key_code  = 8'h0d;
    rst_n         = 1'b0;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.key_code  = 8'h00;
    check("T6 no enter1", 128'(c_e1 - e1), 128'(0));
    check("T6 strobes zero", 128'({bus.enter1, bus.enter2, bus.enter3, bus.rejected,
                                   bus.key_err, bus.timeout, bus.busy}), 128'(0));
    check("T6 pass_entry1 zero", bus.pass_entry1, 128'(0));
    check("T6 pass_entry2 zero", bus.pass_entry2, 128'(0));
    check("T6 pass_exit zero", bus.pass_exit, 128'(0));
    check("T6 exit_num zero", 128'(bus.exit_num), 128'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("T6 idle after reset", 128'(bus.busy), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
